// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the vector register file write port.
// Buffers results in a small FIFO and exposes pending-write and forwarding views.
module regfile_wb_queue #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         drain_en,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic [2**ADDR_W-1:0]         pend_mask,
  input  logic [ADDR_W-1:0]            fwd_addr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              full;
  logic              push;
  logic              pop;
  logic [NREG-1:0]   pend_mask_d;
  logic              fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_d;
  logic [PTR_W-1:0]  fwd_idx;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign pop   = drain_en && !empty;

  assign in_ready = !full;
  assign count    = count_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  // Entry payload needs no reset; occupancy is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // Push and pop never target the same slot: that needs count 0 or DEPTH.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
        wr_en_q         <= 1'b1;
        wr_addr_q       <= addr_q[head_q];
        wr_data_q       <= data_q[head_q];
      end else begin
        wr_en_q <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    pend_mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pend_mask_d[addr_q[i]] = 1'b1;
    end
    if (wr_en_q) pend_mask_d[wr_addr_q] = 1'b1;
  end
  assign pend_mask = pend_mask_d;

  // Scan oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    fwd_idx    = '0;
    if (wr_en_q && (wr_addr_q == fwd_addr)) begin
      fwd_hit_d  = 1'b1;
      fwd_data_d = wr_data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = data_q[fwd_idx];
      end
    end
  end
  assign fwd_hit  = fwd_hit_d;
  assign fwd_data = fwd_data_d;

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side feeder for the 128-bit vector register file: accepts execution results over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Drains one entry per cycle into the register file write port (write_en/write_addr/write_data).
- Exposes a pending-write mask and a youngest-match forwarding port, so operand fetch can detect and bypass writes not yet committed.

Parameters:
- DATA_W, 128, result/register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  result valid
- in_ready  output  1  queue can accept; equals !full
- in_addr  input  ADDR_W  destination register
- in_data  input  DATA_W  result data
- drain_en  input  1  register file write port available this cycle
- wr_en  output  1  to register file write_en
- wr_addr  output  ADDR_W  to register file write_addr
- wr_data  output  DATA_W  to register file write_data
- pend_mask  output  2**ADDR_W  bit r set if a write to register r is queued or in wr_* stage
- fwd_addr  input  ADDR_W  forwarding lookup address
- fwd_hit  output  1  a pending write to fwd_addr exists
- fwd_data  output  DATA_W  data of youngest pending write to fwd_addr; 0 when !fwd_hit
- count  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the wr_* stage
- empty  output  1  count==0

Behaviour:
- Reset: clk is the clock; rst_n is a synchronous, active-low reset. While rst_n=0 at a posedge:
  - head/tail pointers and count go to 0;
  - wr_en, wr_addr and wr_data go to 0;
  - all FIFO entries are invalidated, so pend_mask=0 and fwd_hit=0.
  - Reset mid-operation discards all queued results; no wr_en is issued for them.
- Push: at a posedge with in_valid && in_ready, {in_addr, in_data} is written at the tail, the tail advances mod DEPTH and count increments.
  - in_valid while full is ignored and nothing is stored; the producer must hold its request.
- Pop: at a posedge with !empty && drain_en, the head entry is loaded into the wr_* register, wr_en<=1, the head advances mod DEPTH and count decrements.
  - Otherwise wr_en<=0, and wr_addr/wr_data hold their previous values.
- Latency: a result accepted at edge N pops at edge N+1 at the earliest, and wr_en is high in the cycle after edge N+1.
  - The register file commits it at edge N+2.
- No pass-through: an empty queue never drives wr_en in the same cycle as a push.
- Simultaneous push and pop: both occur and count is unchanged.
  - When full, in_ready=0, so a push and a pop cannot coincide; count goes DEPTH-1.
- Ordering: writes reach the port in strict acceptance order. Duplicate addresses are kept and written in order, so the last write wins in the register file.
- pend_mask: combinational OR of the decoded addresses of all valid FIFO entries, plus wr_addr when wr_en=1.
- Forwarding (combinational) searches youngest to oldest: FIFO entries from tail-1 back to head, then the wr_* stage when wr_en=1.
  - The first address match gives fwd_hit=1 and that entry's data.
  - The lookup does not see an in_* value being pushed in the same cycle.
- Pointer wrap: pointers are ADDR-free, $clog2(DEPTH) bits wide, and wrap naturally.
  - Full/empty are derived from count, not from pointer equality.

Test Plan:
- Latency: after reset, drain_en=1; push addr=3 data=128'hA5..A5 at edge 1. Required: wr_en=1, wr_addr=3, wr_data=A5..A5 in the cycle after edge 2 only; pend_mask[3]=1 from edge 1 until wr_en drops.
- Full: drain_en=0; push addrs 1,2,3,4, then a 5th push (addr 5). Required: count=4, in_ready=0, 5th ignored. Then drain_en=1: writes 1,2,3,4 in order on 4 consecutive cycles, count returns to 0.
- Forwarding: drain_en=0; push (7, 0x11), then (7, 0x22); fwd_addr=7. Required: fwd_hit=1, fwd_data=0x22. With fwd_addr=8: fwd_hit=0, fwd_data=0.
- Simultaneous: count=2, drain_en=1, push every cycle for 10 cycles. Required: count stays 2, wr_en=1 every cycle, order preserved across pointer wrap.
- Reset mid-operation: 3 entries queued and wr_en=1; assert rst_n=0 for one edge. Required: wr_en=0, count=0, pend_mask=0, in_ready=1, and no queued write appears after rst_n=1.
